// File: rtl/mem_stream_loader.sv
// Host stream loader: writes a host word stream into shared memory, pulses core_start,
// waits for core_done, then streams a result window back out with a 1-cycle read pipeline.
module mem_stream_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [DATA_W-1:0] host_data_in,
  input  logic              host_valid,
  input  logic              host_last,
  output logic              host_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              core_start,
  input  logic              core_done,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic [ADDR_W:0]   dump_len,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DUMP = 2'd3
  } state_e;

  localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};

  state_e              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                start_q, start_d;
  logic                ovalid_q, ovalid_d;
  logic                olast_q, olast_d;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    len_d      = len_q;
    base_d     = base_q;
    start_d    = 1'b0;
    ovalid_d   = 1'b0;
    olast_d    = 1'b0;
    host_ready = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          count_d = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        host_ready = ~count_q[ADDR_W];
        if (host_valid && host_ready) begin
          mem_we    = 1'b1;
          mem_addr  = count_q[ADDR_W-1:0];
          mem_wdata = host_data_in;
          count_d   = count_q + ONE;
          // Writing the top slot ends the load exactly like host_last would.
          if (host_last || count_q == LAST_IDX) begin
            state_d = S_RUN;
            start_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (core_done) begin
          base_d  = dump_base;
          len_d   = dump_len;
          idx_d   = '0;
          state_d = S_DUMP;
        end
      end
      S_DUMP: begin
        // idx == len is the drain cycle in which the last read's data is presented.
        if (idx_q != len_q) begin
          mem_addr = base_q + idx_q[ADDR_W-1:0];
          idx_d    = idx_q + ONE;
          ovalid_d = 1'b1;
          olast_d  = (idx_d == len_q);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      base_q   <= '0;
      start_q  <= 1'b0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      base_q   <= base_d;
      start_q  <= start_d;
      ovalid_q <= ovalid_d;
      olast_q  <= olast_d;
    end
  end

  assign core_start = start_q;
  assign out_valid  = ovalid_q;
  assign out_last   = olast_q;
  assign out_data   = ovalid_q ? mem_rdata : '0;
  assign state      = state_q;
  assign word_count = count_q;

endmodule
